// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encoding and the
// hard-wired zero register index.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } ctrl_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_stall_controller_hazard_detect.sv
// Load-use hazard compare: flags an ID instruction that reads the register a
// load currently in EX is about to write.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] i_rs1_addr,
    input  logic [4:0] i_rs2_addr,
    input  logic       i_uses_rs1,
    input  logic       i_uses_rs2,
    input  logic [4:0] i_ex_write_addr,
    input  logic       i_ex_mem_read,
    input  logic       i_ex_reg_write_en,
    output logic       o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_uses_rs1 && (i_rs1_addr == i_ex_write_addr);
    assign w_rs2_hit = i_uses_rs2 && (i_rs2_addr == i_ex_write_addr);

    // x0 is hard-wired, so a load targeting it can never feed a consumer.
    assign o_load_use = i_ex_mem_read && i_ex_reg_write_en &&
                        (i_ex_write_addr != REG_X0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer for the 5-stage core: derives per-register stall/flush
// controls from memory busywait, taken branches, MUL/DIV occupancy and load-use.
module hazard_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_write_addr,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write_en,
    input  logic        ex_is_muldiv,
    input  logic        ex_branch_taken,
    input  logic        dmem_busywait,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        mem_wb_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        muldiv_start,
    output logic [31:0] stall_count
);

    localparam logic [CNT_W-1:0] MD_INIT =
        CNT_W'((MULDIV_CYCLES > 1) ? MULDIV_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ctrl_state_t      r_state;
    ctrl_state_t      w_next_state;
    logic [CNT_W-1:0] r_md_cnt;
    logic [CNT_W-1:0] w_next_md_cnt;
    logic [31:0]      r_stall_count;
    logic             w_load_use;

    hazard_detect u_hazard_detect (
        .i_rs1_addr        (id_rs1_addr),
        .i_rs2_addr        (id_rs2_addr),
        .i_uses_rs1        (id_uses_rs1),
        .i_uses_rs2        (id_uses_rs2),
        .i_ex_write_addr   (ex_write_addr),
        .i_ex_mem_read     (ex_mem_read),
        .i_ex_reg_write_en (ex_reg_write_en),
        .o_load_use        (w_load_use)
    );

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        mem_wb_stall  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        muldiv_start  = 1'b0;
        w_next_state  = r_state;
        w_next_md_cnt = r_md_cnt;

        if (reset) begin
            w_next_state  = RUN;
            w_next_md_cnt = '0;
        end else if (dmem_busywait) begin
            // Freeze the whole pipe; the MUL/DIV unit keeps counting on its own.
            {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall} = 5'b11111;
            if (r_md_cnt != '0) w_next_md_cnt = r_md_cnt - CNT_ONE;
        end else if (r_state == MD_BUSY) begin
            if (r_md_cnt != '0) begin
                {pc_stall, if_id_stall, id_ex_stall} = 3'b111;
                ex_mem_flush  = 1'b1;
                w_next_md_cnt = r_md_cnt - CNT_ONE;
            end else begin
                w_next_state = RUN;
            end
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (ex_is_muldiv && (MULDIV_CYCLES > 1)) begin
            muldiv_start  = 1'b1;
            {pc_stall, if_id_stall, id_ex_stall} = 3'b111;
            ex_mem_flush  = 1'b1;
            w_next_state  = MD_BUSY;
            w_next_md_cnt = MD_INIT;
        end else if (w_load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_state       <= RUN;
            r_md_cnt      <= '0;
            r_stall_count <= '0;
        end else begin
            r_state  <= w_next_state;
            r_md_cnt <= w_next_md_cnt;
            if (pc_stall) r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = reset ? 32'd0 : r_stall_count;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a time-based reference model.
module tb_hazard_stall_controller;

    localparam int M = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_write_addr;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_reg_write_en;
    logic        ex_is_muldiv, ex_branch_taken, dmem_busywait;
    logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, muldiv_start;
    logic [31:0] stall_count;

    int n_vectors = 0;
    int n_miscompares = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(.MULDIV_CYCLES(M), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_write_addr(ex_write_addr), .ex_mem_read(ex_mem_read),
        .ex_reg_write_en(ex_reg_write_en), .ex_is_muldiv(ex_is_muldiv),
        .ex_branch_taken(ex_branch_taken), .dmem_busywait(dmem_busywait),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .muldiv_start(muldiv_start),
        .stall_count(stall_count)
    );

    // {pc, if_id, id_ex, ex_mem, mem_wb stalls, if_id, id_ex, ex_mem flushes, muldiv_start}
    logic [8:0] outs;
    assign outs = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                   if_id_flush, id_ex_flush, ex_mem_flush, muldiv_start};

    localparam logic [8:0] E_NONE   = 9'b00000_000_0;
    localparam logic [8:0] E_LOADU  = 9'b11000_010_0;
    localparam logic [8:0] E_MDSTRT = 9'b11100_001_1;
    localparam logic [8:0] E_MDBUSY = 9'b11100_001_0;
    localparam logic [8:0] E_BRANCH = 9'b00000_110_0;
    localparam logic [8:0] E_BUSYW  = 9'b11111_000_0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a MUL/DIV op started at cycle t0 holds EX until
    // M-1 cycles have elapsed, then releases on the first cycle memory is ready.
    bit          m_active = 1'b0;
    int          m_t0 = 0;
    int          cyc = 0;
    logic [31:0] m_count = 32'd0;

    always @(negedge clk) begin : compare
        logic [8:0] e;
        logic       lu;
        bit         nxt_active;
        lu = ex_mem_read && ex_reg_write_en && (ex_write_addr != 5'd0) &&
             ((id_uses_rs1 && id_rs1_addr == ex_write_addr) ||
              (id_uses_rs2 && id_rs2_addr == ex_write_addr));
        e = E_NONE;
        nxt_active = m_active;
        if (reset) begin
            nxt_active = 1'b0;
        end else if (dmem_busywait) begin
            e = E_BUSYW;
        end else if (m_active) begin
            if (cyc - m_t0 < M - 1) e = E_MDBUSY;
            else nxt_active = 1'b0;
        end else if (ex_branch_taken) begin
            e = E_BRANCH;
        end else if (ex_is_muldiv) begin
            e = E_MDSTRT;
            nxt_active = 1'b1;
            m_t0 = cyc;
        end else if (lu) begin
            e = E_LOADU;
        end
        check("model_outputs", {23'd0, outs}, {23'd0, e});
        check("model_stall_count", stall_count, reset ? 32'd0 : m_count);
        if (reset) m_count = 32'd0;
        else if (e[8]) m_count = m_count + 32'd1;
        m_active = nxt_active;
        cyc++;
    end

    task automatic idle();
        id_rs1_addr = '0; id_rs2_addr = '0; ex_write_addr = '0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_reg_write_en = 0;
        ex_is_muldiv = 0; ex_branch_taken = 0; dmem_busywait = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input string name, input logic [8:0] e);
        @(negedge clk);
        check(name, {23'd0, outs}, {23'd0, e});
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1);
        idle();
        ex_mem_read = 1; ex_reg_write_en = 1; ex_write_addr = rd;
        id_uses_rs1 = 1; id_rs1_addr = rs1;
    endtask

    initial begin
        // 1: reset with every input high
        reset = 1;
        {id_rs1_addr, id_rs2_addr, ex_write_addr} = '1;
        {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_reg_write_en} = '1;
        {ex_is_muldiv, ex_branch_taken, dmem_busywait} = '1;
        expect_cycle("reset_c0", E_NONE);
        check("reset_cnt0", stall_count, 32'd0);
        expect_cycle("reset_c1", E_NONE);
        check("reset_cnt1", stall_count, 32'd0);
        step(); reset = 0; idle();
        expect_cycle("idle_after_reset", E_NONE);

        // 2: load-use on x5, then the same pattern on x0
        step(); set_load(5'd5, 5'd5);
        expect_cycle("load_use_x5", E_LOADU);
        step(); set_load(5'd0, 5'd0);
        expect_cycle("load_use_x0", E_NONE);
        check("cnt_after_load_use", stall_count, 32'd1);

        // 3: MUL/DIV occupies EX for exactly M cycles
        step(); idle(); ex_is_muldiv = 1;
        expect_cycle("md_c0", E_MDSTRT);
        step(); expect_cycle("md_c1", E_MDBUSY);
        step(); expect_cycle("md_c2", E_MDBUSY);
        step(); expect_cycle("md_release", E_NONE);
        step(); idle();
        expect_cycle("md_after", E_NONE);
        check("cnt_after_md", stall_count, 32'd4);

        // 4: taken branch wins over a simultaneous load-use match
        step(); set_load(5'd7, 5'd7); ex_branch_taken = 1;
        expect_cycle("branch_over_lu", E_BRANCH);
        check("cnt_after_branch", stall_count, 32'd4);

        // 5: busywait for 3 cycles while the MUL/DIV counter runs out
        step(); idle(); ex_is_muldiv = 1;
        expect_cycle("md2_start", E_MDSTRT);
        for (int i = 0; i < 3; i++) begin
            step(); dmem_busywait = 1;
            expect_cycle("busywait_in_md", E_BUSYW);
        end
        step(); dmem_busywait = 0;
        expect_cycle("md2_release", E_NONE);
        step(); idle();
        expect_cycle("md2_after", E_NONE);
        check("cnt_after_busywait", stall_count, 32'd8);

        // 6: reset in the middle of a MUL/DIV op
        step(); ex_is_muldiv = 1;
        expect_cycle("md3_start", E_MDSTRT);
        step(); expect_cycle("md3_busy", E_MDBUSY);
        step(); reset = 1;
        expect_cycle("md3_reset", E_NONE);
        step(); reset = 0; idle();
        expect_cycle("md3_after_reset", E_NONE);
        check("cnt_after_md_reset", stall_count, 32'd0);

        // Randomized traffic; EX keeps its MUL/DIV op while the model says it is busy.
        for (int i = 0; i < 4000; i++) begin
            step();
            reset         = ($urandom_range(0, 99) < 2);
            dmem_busywait = ($urandom_range(0, 99) < 15);
            id_rs1_addr   = 5'($urandom_range(0, 3));
            id_rs2_addr   = 5'($urandom_range(0, 3));
            ex_write_addr = 5'($urandom_range(0, 3));
            id_uses_rs1   = 1'($urandom_range(0, 1));
            id_uses_rs2   = 1'($urandom_range(0, 1));
            ex_reg_write_en = ($urandom_range(0, 99) < 80);
            if (m_active) begin
                ex_is_muldiv = 1; ex_branch_taken = 0; ex_mem_read = 0;
            end else begin
                ex_is_muldiv    = ($urandom_range(0, 99) < 15);
                ex_branch_taken = ($urandom_range(0, 99) < 12);
                ex_mem_read     = !ex_is_muldiv && ($urandom_range(0, 99) < 50);
            end
        end
        step(); idle(); reset = 0;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
